// File: rtl/mem_responder.sv
// Host-side memory responder: owns the instruction and data memories of a small
// processor, lets a host preload/inspect them, and supervises one run at a time.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_CYCLES = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr,
  input  logic                  host_sel,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_w_data,
  input  logic                  host_go,
  output logic [DATA_WIDTH-1:0] host_r_data,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           run_cycles
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0] MAX_LIMIT = 32'(MAX_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] im_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] dm_mem [0:DEPTH-1];

  logic                  start_next;
  logic                  timeout_next;
  logic [15:0]           run_cycles_next;
  logic [15:0]           count_inc;
  logic                  at_limit;
  logic                  im_we;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_waddr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  proc_active;

  assign done        = (state == DONE);
  assign proc_active = (state == RUN);

  // The limit compares against the count this cycle will produce, so a timed-out
  // run ends with exactly MAX_CYCLES RUN cycles and run_cycles == MAX_CYCLES.
  assign count_inc = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
  assign at_limit  = ({16'd0, count_inc} == MAX_LIMIT);

  always_comb begin
    state_next      = state;
    start_next      = 1'b0;
    timeout_next    = timeout;
    run_cycles_next = run_cycles;
    im_we           = 1'b0;
    dm_we           = 1'b0;
    dm_waddr        = host_addr;
    dm_wdata        = host_w_data;

    case (state)
      IDLE: begin
        im_we = host_wr && !host_sel;
        dm_we = host_wr && host_sel;
        if (host_go) begin
          state_next      = RUN;
          start_next      = 1'b1;
          timeout_next    = 1'b0;
          run_cycles_next = 16'd0;
        end
      end

      RUN: begin
        run_cycles_next = count_inc;
        dm_we           = dm_wr;
        dm_waddr        = dm_addr;
        dm_wdata        = dm_w_data;
        // A stop seen while start is still pulsing is stale from the previous run.
        if (stop && !start) begin
          state_next = DONE;
        end else if (at_limit) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end
      end

      DONE: begin
        im_we = host_wr && !host_sel;
        dm_we = host_wr && host_sel;
        if (host_go) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start      <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= 16'd0;
    end else begin
      state      <= state_next;
      start      <= start_next;
      timeout    <= timeout_next;
      run_cycles <= run_cycles_next;
    end
  end

  // Memories have no reset so contents survive rst; writes are simply gated off.
  always_ff @(posedge clk) begin
    if (!rst && im_we) begin
      im_mem[host_addr] <= host_w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dm_we) begin
      dm_mem[dm_waddr] <= dm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_r_data <= '0;
      dm_r_data <= '0;
    end else begin
      if (proc_active && im_rd) begin
        im_r_data <= im_mem[im_addr];
      end
      if (proc_active && dm_rd) begin
        dm_r_data <= dm_mem[dm_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_r_data <= '0;
    end else begin
      host_r_data <= host_sel ? dm_mem[host_addr] : im_mem[host_addr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table-driven host preload/readback, then
// hand-written run sequences for start/stop, timeout and mid-run reset.
module tb_mem_responder;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr;
  logic          host_sel;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_w_data;
  logic          host_go;
  logic [DW-1:0] host_r_data;
  logic          start;
  logic          stop;
  logic [AW-1:0] im_addr;
  logic          im_rd;
  logic [DW-1:0] im_r_data;
  logic [AW-1:0] dm_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [DW-1:0] dm_w_data;
  logic [DW-1:0] dm_r_data;
  logic          done;
  logic          timeout;
  logic [15:0]   run_cycles;

  int n_vectors     = 0;
  int n_miscompares = 0;

  typedef struct {
    logic          wr;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          chk;
    logic [DW-1:0] exp_r;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_wr    (host_wr),
    .host_sel   (host_sel),
    .host_addr  (host_addr),
    .host_w_data(host_w_data),
    .host_go    (host_go),
    .host_r_data(host_r_data),
    .start      (start),
    .stop       (stop),
    .im_addr    (im_addr),
    .im_rd      (im_rd),
    .im_r_data  (im_r_data),
    .dm_addr    (dm_addr),
    .dm_rd      (dm_rd),
    .dm_wr      (dm_wr),
    .dm_w_data  (dm_w_data),
    .dm_r_data  (dm_r_data),
    .done       (done),
    .timeout    (timeout),
    .run_cycles (run_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    host_wr     = v.wr;
    host_sel    = v.sel;
    host_addr   = v.addr;
    host_w_data = v.wdata;
    step();
    if (v.chk) begin
      check_output($sformatf("vec%0d host_r_data", idx), 32'(host_r_data), 32'(v.exp_r));
    end
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, " start"},       32'(start),       32'd0);
    check_output({tag, " done"},        32'(done),        32'd0);
    check_output({tag, " timeout"},     32'(timeout),     32'd0);
    check_output({tag, " run_cycles"},  32'(run_cycles),  32'd0);
    check_output({tag, " im_r_data"},   32'(im_r_data),   32'd0);
    check_output({tag, " dm_r_data"},   32'(dm_r_data),   32'd0);
    check_output({tag, " host_r_data"}, 32'(host_r_data), 32'd0);
  endtask

  initial begin
    // wr, sel, addr, wdata, chk, expected host_r_data
    vecs[0]  = '{1'b1, 1'b0, 8'd0, 16'h1111, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 8'd1, 16'h2222, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 8'd2, 16'h3333, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 8'd3, 16'h4444, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 8'd5, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 8'd6, 16'h0000, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 8'd2, 16'hD2D2, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 8'd7, 16'h7777, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 16'h1111};
    vecs[9]  = '{1'b0, 1'b0, 8'd1, 16'h0000, 1'b1, 16'h2222};
    vecs[10] = '{1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 16'h3333};
    vecs[11] = '{1'b0, 1'b0, 8'd3, 16'h0000, 1'b1, 16'h4444};
    vecs[12] = '{1'b1, 1'b0, 8'd3, 16'h9999, 1'b1, 16'h4444};
    vecs[13] = '{1'b1, 1'b0, 8'd3, 16'h4444, 1'b1, 16'h9999};
    vecs[14] = '{1'b0, 1'b0, 8'd3, 16'h0000, 1'b1, 16'h4444};
    vecs[15] = '{1'b0, 1'b1, 8'd2, 16'h0000, 1'b1, 16'hD2D2};
    vecs[16] = '{1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 16'h3333};
    vecs[17] = '{1'b0, 1'b1, 8'd7, 16'h0000, 1'b1, 16'h7777};
    vecs[18] = '{1'b0, 1'b1, 8'd5, 16'h0000, 1'b1, 16'h0000};

    rst = 1'b1; host_wr = 1'b0; host_sel = 1'b0; host_addr = '0; host_w_data = '0;
    host_go = 1'b0; stop = 1'b0; im_addr = '0; im_rd = 1'b0;
    dm_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_w_data = '0;
    step();
    step();
    check_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(i, vecs[i]);
    end

    // Launch with a same-cycle host write, which must still land.
    host_wr = 1'b1; host_sel = 1'b1; host_addr = 8'd9; host_w_data = 16'h9009;
    host_go = 1'b1;
    step();
    check_output("launch start", 32'(start), 32'd1);
    check_output("launch run_cycles", 32'(run_cycles), 32'd0);
    host_wr = 1'b0; host_go = 1'b0;
    im_rd = 1'b1; im_addr = 8'd2; stop = 1'b1;
    step();
    check_output("start one cycle", 32'(start), 32'd0);
    check_output("im read addr2", 32'(im_r_data), 32'h3333);
    check_output("stop in start cycle ignored", 32'(done), 32'd0);
    check_output("run_cycles 1", 32'(run_cycles), 32'd1);

    im_rd = 1'b0; im_addr = 8'd0; stop = 1'b0;
    dm_wr = 1'b1; dm_rd = 1'b1; dm_addr = 8'd5; dm_w_data = 16'hBEEF;
    host_wr = 1'b1; host_sel = 1'b1; host_addr = 8'd6; host_w_data = 16'h6666;
    step();
    check_output("dm read-before-write", 32'(dm_r_data), 32'h0000);
    check_output("im_r_data hold", 32'(im_r_data), 32'h3333);
    dm_wr = 1'b0; host_wr = 1'b0;
    step();
    check_output("dm read new", 32'(dm_r_data), 32'hBEEF);
    dm_rd = 1'b0; dm_addr = 8'd0;
    step();
    check_output("dm_r_data hold", 32'(dm_r_data), 32'hBEEF);
    for (int i = 0; i < 5; i++) step();
    check_output("run before stop done", 32'(done), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_output("stop done", 32'(done), 32'd1);
    check_output("stop timeout", 32'(timeout), 32'd0);
    check_output("stop run_cycles", 32'(run_cycles), 32'd10);

    // DONE: host reads allowed, processor requests ignored.
    host_sel = 1'b1; host_addr = 8'd5;
    dm_wr = 1'b1; dm_addr = 8'd5; dm_w_data = 16'hDEAD; im_rd = 1'b1; im_addr = 8'd0;
    step();
    check_output("done host DM5", 32'(host_r_data), 32'hBEEF);
    check_output("done im read ignored", 32'(im_r_data), 32'h3333);
    dm_wr = 1'b0; im_rd = 1'b0; host_addr = 8'd9;
    step();
    check_output("launch-cycle host write", 32'(host_r_data), 32'h9009);
    host_addr = 8'd5;
    step();
    check_output("done dm write ignored", 32'(host_r_data), 32'hBEEF);
    host_addr = 8'd6;
    step();
    check_output("run host write ignored", 32'(host_r_data), 32'h0000);
    check_output("done run_cycles hold", 32'(run_cycles), 32'd10);
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    check_output("ack to idle done", 32'(done), 32'd0);
    check_output("ack run_cycles hold", 32'(run_cycles), 32'd10);

    // Timeout run: stop never asserted.
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    for (int i = 0; i < MAXC - 1; i++) step();
    check_output("pre-limit done", 32'(done), 32'd0);
    check_output("pre-limit run_cycles", 32'(run_cycles), 32'(MAXC - 1));
    step();
    check_output("limit done", 32'(done), 32'd1);
    check_output("limit timeout", 32'(timeout), 32'd1);
    check_output("limit run_cycles", 32'(run_cycles), 32'(MAXC));
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    check_output("ack timeout sticky", 32'(timeout), 32'd1);
    check_output("ack state idle", 32'(done), 32'd0);
    step();
    check_output("idle timeout sticky", 32'(timeout), 32'd1);
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    check_output("relaunch clears timeout", 32'(timeout), 32'd0);
    check_output("relaunch start", 32'(start), 32'd1);

    // Stop coinciding with the limit wins over timeout.
    for (int i = 0; i < MAXC - 1; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_output("stop at limit done", 32'(done), 32'd1);
    check_output("stop at limit timeout", 32'(timeout), 32'd0);
    check_output("stop at limit run_cycles", 32'(run_cycles), 32'(MAXC));
    host_go = 1'b1;
    step();
    host_go = 1'b0;

    // Mid-run reset with a DM write pending.
    host_go = 1'b1;
    step();
    host_go = 1'b0;
    step();
    step();
    rst = 1'b1; dm_wr = 1'b1; dm_addr = 8'd5; dm_w_data = 16'h1234;
    step();
    check_cleared("mid-run reset");
    rst = 1'b0; dm_wr = 1'b0; host_sel = 1'b1; host_addr = 8'd5;
    step();
    check_output("post-reset DM5", 32'(host_r_data), 32'hBEEF);
    check_output("post-reset no start", 32'(start), 32'd0);
    check_output("post-reset idle count", 32'(run_cycles), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
